uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
- REQ-001 Parameter NUM_REQ, default 2: number of byte requesters sharing one UART TX path (legal 2..8).
- REQ-002 Parameter CLK_FREQ, default 50_000_000: clk_in frequency in Hz.
- REQ-003 Parameter BAUD, default 115200: line baud rate.
- REQ-004 Parameter FRAME_BITS, default 11: bit times reserved per byte (start + 8 data + stop + 1 guard).
- REQ-005 clk_in  in  1  single clock; all logic on its rising edge.
- REQ-006 rst_in  in  1  reset, synchronous, active-high.
- REQ-007 req_valid  in  NUM_REQ  per-requester byte-pending flag.
- REQ-008 req_data  in  8*NUM_REQ  byte of requester i on bits [8i+7:8i].
- REQ-009 req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- REQ-010 uart_tx_data  out  8  byte for the UART TX path.
- REQ-011 uart_tx_enable  out  1  one-cycle start pulse for the UART TX path.
- REQ-012 busy  out  1  high while a frame is in flight.
- REQ-013 grant_id  out  clog2(NUM_REQ)  index of the requester whose byte was last accepted.

Function
- REQ-014 FRAME_CYCLES SHALL be (CLK_FREQ/BAUD)*FRAME_BITS with integer division.
- REQ-015 FSM states: IDLE, SEND, WAIT.
- REQ-016 IDLE: if any req_valid, SHALL assert req_ready of the winner combinationally in that cycle, latch its byte into uart_tx_data, latch grant_id, and go to SEND; otherwise stay in IDLE.
- REQ-017 SEND lasts exactly 1 cycle with uart_tx_enable=1; then go to WAIT.
- REQ-018 WAIT lasts exactly FRAME_CYCLES-1 cycles (down-counter loaded on entry); then go to IDLE.
- REQ-019 With continuous requests, consecutive uart_tx_enable pulses SHALL be exactly FRAME_CYCLES+1 cycles apart.
- REQ-020 At most one req_ready bit SHALL be high in any cycle, and only in IDLE.
- REQ-021 uart_tx_data SHALL remain stable from acceptance until the next acceptance.
- REQ-022 busy SHALL be 1 in SEND and WAIT, 0 in IDLE.
- REQ-023 Deasserting req_valid before acceptance SHALL withdraw the request without side effects.
- REQ-024 req_data changes after acceptance SHALL NOT affect uart_tx_data.

Reset
- REQ-025 rst_in SHALL force IDLE, counter 0, uart_tx_data 0, uart_tx_enable 0, req_ready 0, busy 0, grant_id 0, and the round-robin pointer to NUM_REQ-1.
- REQ-026 Reset in SEND or WAIT SHALL abort the frame with no further enable pulse; the aborted byte is discarded.

Configuration
- REQ-027 Macro UART_TX_ARB_RR_EN defined: round-robin; the search starts at pointer+1 mod NUM_REQ, and the pointer updates to the winner on each acceptance.
- REQ-028 UART_TX_ARB_RR_EN undefined: fixed priority; the lowest index with req_valid wins, and no pointer register exists.

Structure
- REQ-029 Package uart_pkg SHALL hold the FSM state enum and a FRAME_CYCLES calculation function shared with other UART blocks.
- REQ-030 Sub-module uart_frame_timer SHALL implement the WAIT down-counter: load/start input, done output, width clog2(FRAME_CYCLES).

Verification (CLK_FREQ=1000, BAUD=100, FRAME_BITS=11 -> FRAME_CYCLES=110)
- REQ-031 Single request: req_valid[0]=1, data 0x55 -> req_ready[0] pulses once, next cycle uart_tx_enable=1 with uart_tx_data=0x55, busy high for 110 cycles.
- REQ-032 Back-to-back: req0 held valid with bytes 0x01, 0x02 -> enable pulses exactly 111 cycles apart, data 0x01 then 0x02.
- REQ-033 Contention with RR_EN: both valid continuously after reset -> grants 0,1,0,1; grant_id follows the same sequence.
- REQ-034 Contention without RR_EN: both valid continuously -> grants 0,0,0; req1 is granted only after req0 drops.
- REQ-035 Reset mid-WAIT: rst_in high at cycle 50 of WAIT -> no enable pulse, busy=0 and uart_tx_data=0 the next cycle, and a new request is accepted the first cycle after rst_in falls.
- REQ-036 Withdrawal: req1 valid only in a WAIT cycle, then dropped -> no req_ready[1] and no extra frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM states and frame timing helper.
// Imported by uart_tx_arbiter and uart_frame_timer.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT
  } state_e;

  function automatic int frame_cycles(
    input int clk_freq,
    input int baud,
    input int frame_bits
  );
    return (clk_freq / baud) * frame_bits;
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Frame down-counter: load on SEND, done when it reaches zero.
// Loaded with CYCLES-2 so WAIT spans CYCLES-1 cycles.
module uart_frame_timer
  import uart_pkg::*;
#(
  parameter int unsigned CYCLES = 110
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic done_o
);

  localparam int unsigned W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: reload, else count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = W'(CYCLES - 2);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX path between NUM_REQ byte requesters.
// UART_TX_ARB_RR_EN selects round-robin; default is fixed priority.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FRAME_BITS = 11,
  localparam int IDW       = $clog2(NUM_REQ)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             uart_tx_data,
  output logic                   uart_tx_enable,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id
);

  localparam int FRAME_CYCLES =
    frame_cycles(CLK_FREQ, BAUD, FRAME_BITS);

  state_e         state_q, state_d;
  logic [7:0]     data_q, data_d;
  logic [IDW-1:0] gid_q, gid_d;
  logic [IDW-1:0] win;
  logic           any;
  logic           accept;
  logic           load;
  logic           done;

`ifdef UART_TX_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  int             rr_idx;

  // Round-robin search starting just after the last winner.
  always_comb begin
    win    = '0;
    any    = 1'b0;
    rr_idx = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_idx = (int'(ptr_q) + 1 + k) % NUM_REQ;
      if (!any && req_valid[rr_idx]) begin
        any = 1'b1;
        win = IDW'(rr_idx);
      end
    end
    ptr_d = accept ? win : ptr_q;
  end

  // Pointer register; reset so index 0 is searched first.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ptr_q <= IDW'(NUM_REQ - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  // Fixed priority: lowest valid index wins.
  always_comb begin
    win = '0;
    any = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any && req_valid[k]) begin
        any = 1'b1;
        win = IDW'(k);
      end
    end
  end
`endif

  assign accept = (state_q == IDLE) && any && !rst_in;

  // Next state and handshake outputs.
  always_comb begin
    state_d        = state_q;
    data_d         = data_q;
    gid_d          = gid_q;
    req_ready      = '0;
    uart_tx_enable = 1'b0;
    load           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          req_ready = NUM_REQ'(1) << win;
          data_d    = req_data[8*int'(win) +: 8];
          gid_d     = win;
          state_d   = SEND;
        end
      end
      SEND: begin
        uart_tx_enable = !rst_in;
        load           = 1'b1;
        state_d        = WAIT;
      end
      WAIT: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched byte and grant registers.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      data_q  <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
    end
  end

  uart_frame_timer #(
    .CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clk_i (clk_in),
    .rst_i (rst_in),
    .load_i(load),
    .done_o(done)
  );

  assign busy         = (state_q != IDLE);
  assign uart_tx_data = data_q;
  assign grant_id     = gid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter, FRAME_CYCLES = 110.
// Grant order expectations follow UART_TX_ARB_RR_EN.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  valid = '0;
  logic [15:0] data = '0;
  logic [1:0]  ready;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        busy;
  logic [0:0]  gid;

  uart_tx_arbiter #(
    .NUM_REQ(2),
    .CLK_FREQ(1000),
    .BAUD(100),
    .FRAME_BITS(11)
  ) dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .req_valid     (valid),
    .req_data      (data),
    .req_ready     (ready),
    .uart_tx_data  (tx_data),
    .uart_tx_enable(tx_en),
    .busy          (busy),
    .grant_id      (gid)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    ntests++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int         cyc = 0;
  int         busy_cnt = 0;
  int         viol = 0;
  int         en_cyc[$];
  logic [7:0] en_dat[$];
  int         en_gid[$];
  int         rdy_cyc[$];
  int         rdy_idx[$];

  // Event logger and handshake invariant monitor.
  always @(negedge clk) begin
    cyc++;
    if (busy) busy_cnt++;
    if (tx_en) begin
      en_cyc.push_back(cyc);
      en_dat.push_back(tx_data);
      en_gid.push_back(int'(gid));
    end
    if (ready != '0) begin
      rdy_cyc.push_back(cyc);
      rdy_idx.push_back(ready[1] ? 1 : 0);
    end
    if ($countones(ready) > 1 || (ready != '0 && busy))
      viol++;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    en_cyc.delete();
    en_dat.delete();
    en_gid.delete();
    rdy_cyc.delete();
    rdy_idx.delete();
    busy_cnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_rdy(input int idx, input int maxc,
                          input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (ready[idx]) ok = 1'b1;
    end
    check({tag, "_rdy"}, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_any(input int maxc, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (ready != '0) ok = 1'b1;
    end
    check({tag, "_any"}, 32'(ok), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic int qi(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  function automatic int qd(input logic [7:0] q[$], input int i);
    return (q.size() > i) ? int'(q[i]) : -1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int exp_idx[5];
  int cnt1;

  initial begin
`ifdef UART_TX_ARB_RR_EN
    exp_idx = '{0, 1, 0, 1, 1};
`else
    exp_idx = '{0, 0, 0, 0, 1};
`endif
    // reset state, with a request pending during reset
    #1;
    valid = 2'b01;
    data  = 16'h005A;
    step(3);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_en", 32'(tx_en), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_data", 32'(tx_data), 32'd0);
    check("rst_gid", 32'(gid), 32'd0);
    valid = '0;
    rst   = 1'b0;
    step(2);
    clear_logs();

    // single request
    data  = 16'h0055;
    valid = 2'b01;
    wait_rdy(0, 20, "t1");
    valid = '0;
    step(130);
    check("t1_nrdy", 32'(rdy_cyc.size()), 32'd1);
    check("t1_nen", 32'(en_cyc.size()), 32'd1);
    check("t1_lat", 32'(qi(en_cyc, 0) - qi(rdy_cyc, 0)), 32'd1);
    check("t1_data", 32'(qd(en_dat, 0)), 32'h55);
    check("t1_busy", 32'(busy_cnt), 32'd110);
    check("t1_idle", 32'(busy), 32'd0);

    // back-to-back from one requester
    clear_logs();
    data  = 16'h0001;
    valid = 2'b01;
    wait_rdy(0, 20, "t2a");
    data = 16'h0002;
    wait_rdy(0, 200, "t2b");
    valid = '0;
    step(130);
    check("t2_nen", 32'(en_cyc.size()), 32'd2);
    check("t2_gap", 32'(qi(en_cyc, 1) - qi(en_cyc, 0)), 32'd111);
    check("t2_d0", 32'(qd(en_dat, 0)), 32'h01);
    check("t2_d1", 32'(qd(en_dat, 1)), 32'h02);
    check("t2_hold", 32'(tx_data), 32'h02);

    // contention
    do_reset();
    clear_logs();
    data  = 16'hB1A0;
    valid = 2'b11;
    repeat (4) wait_any(200, "t3");
    valid = 2'b10;
    wait_any(200, "t3e");
    valid = '0;
    step(130);
    check("t3_n", 32'(rdy_idx.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t3_idx%0d", i),
            32'(qi(rdy_idx, i)), 32'(exp_idx[i]));
      check($sformatf("t3_gid%0d", i),
            32'(qi(en_gid, i)), 32'(exp_idx[i]));
      check($sformatf("t3_dat%0d", i), 32'(qd(en_dat, i)),
            (exp_idx[i] == 1) ? 32'hB1 : 32'hA0);
    end

    // reset in the middle of WAIT
    clear_logs();
    data  = 16'h0077;
    valid = 2'b01;
    wait_rdy(0, 20, "t4");
    valid = '0;
    step(50);
    check("t4_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    step(1);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_data", 32'(tx_data), 32'd0);
    check("t4_en", 32'(tx_en), 32'd0);
    check("t4_gid", 32'(gid), 32'd0);
    rst   = 1'b0;
    data  = 16'h003C;
    valid = 2'b01;
    @(negedge clk);
    check("t4_rdy", 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    valid = '0;
    step(5);
    check("t4_nen", 32'(en_cyc.size()), 32'd2);
    check("t4_d1", 32'(qd(en_dat, 1)), 32'h3C);
    step(130);

    // withdrawn request
    clear_logs();
    data  = 16'h9911;
    valid = 2'b01;
    wait_rdy(0, 20, "t5");
    valid = '0;
    step(20);
    valid = 2'b10;
    step(1);
    valid = '0;
    step(250);
    cnt1 = 0;
    foreach (rdy_idx[i]) if (rdy_idx[i] == 1) cnt1++;
    check("t5_nrdy", 32'(rdy_cyc.size()), 32'd1);
    check("t5_nen", 32'(en_cyc.size()), 32'd1);
    check("t5_r1", 32'(cnt1), 32'd0);

    check("inv_viol", 32'(viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
